int_to_fp: RTL and testbench

Multi-cycle converter from a signed two's-complement integer to the team's custom floating-point format: sign bit, `expWidth` exponent bits, `mantissaWidth` fraction bits, with a hidden leading one. It packs results into the same encoding that the floating-point arithmetic units unpack. It uses the same start/ready handshake as those units, so integer sources can feed the FP datapath directly. Normalization is iterative, one bit per cycle.

---
 rtl/fp_pkg.sv | 37 +++
 rtl/int_to_fp_if.sv | 19 +
 rtl/fp_round_pack.sv | 45 ++++
 rtl/int_to_fp.sv | 98 +++++++++
 tb/tb_int_to_fp.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point package: state encoding, default field widths, bias
// and field-slice helpers used by the converter and the FP arithmetic units.
package fp_pkg;

    localparam int FP_EXP_WIDTH  = 7;
    localparam int FP_MANT_WIDTH = 24;
    localparam int FP_INT_WIDTH  = 32;
    localparam int FP_WORD_WIDTH = FP_EXP_WIDTH + FP_MANT_WIDTH + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABS,
        ST_NORM,
        ST_PACK,
        ST_DONE
    } state_t;

    typedef logic [FP_WORD_WIDTH-1:0] fp_word_t;

    function automatic int fp_bias(input int exp_width);
        return (1 << (exp_width - 1)) - 1;
    endfunction

    // Field slices for the default format: sign in the MSB, exponent next, fraction lowest.
    function automatic logic fp_sign(input fp_word_t word);
        return word[FP_WORD_WIDTH-1];
    endfunction

    function automatic logic [FP_EXP_WIDTH-1:0] fp_exp(input fp_word_t word);
        return word[FP_WORD_WIDTH-2 -: FP_EXP_WIDTH];
    endfunction

    function automatic logic [FP_MANT_WIDTH-1:0] fp_frac(input fp_word_t word);
        return word[FP_MANT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/int_to_fp_if.sv
// Start/ready handshake bundle between an integer source and the int_to_fp converter.
interface int_to_fp_if
    import fp_pkg::*;
#(
    parameter int expWidth      = FP_EXP_WIDTH,
    parameter int mantissaWidth = FP_MANT_WIDTH,
    parameter int intWidth      = FP_INT_WIDTH
);

    logic                            start;
    logic [intWidth-1:0]             x;
    logic [expWidth+mantissaWidth:0] s;
    logic                            ready;
    logic                            busy;

    modport master (output start, x, input s, ready, busy);
    modport slave  (input start, x, output s, ready, busy);

endinterface

// File: rtl/fp_round_pack.sv
// Combinational rounding and packing of a normalized magnitude.
// INT_TO_FP_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the fraction is truncated.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int expWidth      = FP_EXP_WIDTH,
    parameter int mantissaWidth = FP_MANT_WIDTH,
    parameter int intWidth      = FP_INT_WIDTH
) (
    input  logic                            sign,
    input  logic [expWidth-1:0]             exp,
    input  logic [intWidth-2:0]             frac_bits,
    input  logic                            zero,
    output logic [expWidth+mantissaWidth:0] word
);

    localparam int EXT_W = intWidth + mantissaWidth;

    // Bits below the hidden one, padded so a full fraction plus guard always exists.
    logic [EXT_W-1:0]         ext;
    logic [mantissaWidth-1:0] frac;
    logic                     guard;
    logic                     sticky;
    logic                     round_inc;
    logic [mantissaWidth:0]   sum;
    logic [expWidth-1:0]      exp_out;

    assign ext    = {frac_bits, {(mantissaWidth + 1){1'b0}}};
    assign frac   = ext[EXT_W-1 -: mantissaWidth];
    assign guard  = ext[EXT_W-1-mantissaWidth];
    assign sticky = |ext[EXT_W-2-mantissaWidth:0];

`ifdef INT_TO_FP_ROUND_NEAREST_EN
    assign round_inc = guard & (sticky | frac[0]);
`else
    logic unused_round_bits;
    assign unused_round_bits = guard | sticky;
    assign round_inc = 1'b0;
`endif

    assign sum     = {1'b0, frac} + (mantissaWidth + 1)'(round_inc);
    assign exp_out = sum[mantissaWidth] ? exp + expWidth'(1) : exp;
    assign word    = zero ? '0 : {sign, exp_out, sum[mantissaWidth-1:0]};

endmodule

// File: rtl/int_to_fp.sv
// Multi-cycle signed integer to custom floating-point converter, normalizing one bit per cycle.
// Rounding mode is chosen in fp_round_pack via INT_TO_FP_ROUND_NEAREST_EN (default: truncate).
module int_to_fp
    import fp_pkg::*;
#(
    parameter int expWidth      = FP_EXP_WIDTH,
    parameter int mantissaWidth = FP_MANT_WIDTH,
    parameter int intWidth      = FP_INT_WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    int_to_fp_if.slave bus
);

    localparam int                  BIAS     = fp_bias(expWidth);
    localparam logic [expWidth-1:0] EXP_INIT = expWidth'(BIAS + intWidth - 1);

    // The largest exponent must leave room for the rounding carry without reaching all-ones.
    generate
        if (BIAS + intWidth - 1 > (1 << expWidth) - 2) begin : g_bad_config
            $error("int_to_fp: exponent field too narrow for intWidth");
        end
    endgenerate

    state_t                          state;
    state_t                          state_next;
    logic [intWidth-1:0]             x_reg;
    logic [intWidth-1:0]             mag;
    logic [expWidth-1:0]             exp_reg;
    logic                            sign_reg;
    logic                            zero_reg;
    logic [expWidth+mantissaWidth:0] s_reg;
    logic [expWidth+mantissaWidth:0] packed_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.start) state_next = ST_ABS;
            ST_ABS:  state_next = (x_reg == '0) ? ST_PACK : ST_NORM;
            ST_NORM: if (mag[intWidth-1]) state_next = ST_PACK;
            ST_PACK: state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_reg    <= '0;
            mag      <= '0;
            exp_reg  <= '0;
            sign_reg <= 1'b0;
            zero_reg <= 1'b0;
            s_reg    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.start) x_reg <= bus.x;
                ST_ABS: begin
                    sign_reg <= x_reg[intWidth-1];
                    mag      <= x_reg[intWidth-1] ? (~x_reg + intWidth'(1)) : x_reg;
                    exp_reg  <= EXP_INIT;
                    zero_reg <= (x_reg == '0);
                end
                ST_NORM: begin
                    if (!mag[intWidth-1]) begin
                        mag     <= mag << 1;
                        exp_reg <= exp_reg - expWidth'(1);
                    end
                end
                ST_PACK: s_reg <= packed_word;
                default: ;
            endcase
        end
    end

    fp_round_pack #(
        .expWidth      (expWidth),
        .mantissaWidth (mantissaWidth),
        .intWidth      (intWidth)
    ) u_round_pack (
        .sign      (sign_reg),
        .exp       (exp_reg),
        .frac_bits (mag[intWidth-2:0]),
        .zero      (zero_reg),
        .word      (packed_word)
    );

    // DONE immediately follows PACK, so it marks the single cycle in which s is fresh.
    assign bus.s     = s_reg;
    assign bus.ready = (state == ST_DONE);
    assign bus.busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_int_to_fp.sv
// Self-checking bench for int_to_fp: directed cases plus randomized operands against an arithmetic model.
module tb_int_to_fp;

    logic clk;
    logic reset;
    int   n_compared;
    int   n_mismatched;

    int_to_fp_if bus ();

    int_to_fp dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef INT_TO_FP_ROUND_NEAREST_EN
    localparam logic [31:0] MAX_POS_S = 32'h5E000000;
`else
    localparam logic [31:0] MAX_POS_S = 32'h5DFFFFFF;
`endif

    // Reference: exact value = m * 2^0, rounded by comparing the dropped remainder to half an ulp.
    function automatic int ref_msb(input longint m);
        int e;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        return e;
    endfunction

    function automatic logic [31:0] ref_fp(input logic [31:0] xv);
        longint v;
        longint m;
        longint frac;
        int     e;
        int     ee;
        logic   sgn;
`ifdef INT_TO_FP_ROUND_NEAREST_EN
        longint rem;
        longint half;
`endif
        v   = longint'($signed(xv));
        sgn = (v < 0);
        m   = sgn ? -v : v;
        if (m == 0) return 32'h0;
        e = ref_msb(m);
        if (e > 24) begin
            frac = m >> (e - 24);
`ifdef INT_TO_FP_ROUND_NEAREST_EN
            rem  = m - (frac << (e - 24));
            half = longint'(1) << (e - 25);
            if (rem > half || (rem == half && (frac % 2) == 1)) frac++;
`endif
        end else begin
            frac = m << (24 - e);
        end
        ee = 63 + e;
        if (frac >= (longint'(1) << 25)) begin
            frac = frac >> 1;
            ee++;
        end
        return {sgn, 7'(ee), 24'(frac)};
    endfunction

    function automatic int ref_latency(input logic [31:0] xv);
        longint v;
        v = longint'($signed(xv));
        if (v == 0) return 2;
        if (v < 0) v = -v;
        return 3 + 31 - ref_msb(v);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One conversion; poke_cycle >= 1 pulses start with x=5 at that cycle while busy.
    task automatic apply_stimulus(input string tag, input logic [31:0] xv, input logic [31:0] exp_s,
                                  input int exp_lat, input int poke_cycle);
        int          cycles;
        logic        seen;
        logic [31:0] held;
        @(negedge clk);
        bus.start = 1'b1;
        bus.x     = xv;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.x     = $urandom;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 64) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.ready) seen = 1'b1;
            else if (cycles == poke_cycle) begin
                bus.start = 1'b1;
                bus.x     = 32'd5;
            end
        end
        check_output({tag, " ready_seen"}, 32'(seen), 32'd1);
        check_output({tag, " latency"}, 32'(cycles), 32'(exp_lat));
        check_output({tag, " s"}, bus.s, exp_s);
        held = bus.s;
        @(posedge clk);
        @(negedge clk);
        check_output({tag, " ready_pulse"}, 32'(bus.ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_output({tag, " idle_after"}, 32'(bus.busy), 32'd0);
        check_output({tag, " s_hold"}, bus.s, held);
    endtask

    initial begin
        logic [31:0] xv;
        n_compared   = 0;
        n_mismatched = 0;
        bus.start    = 1'b0;
        bus.x        = '0;
        reset        = 1'b0;
        #1;
        check_output("reset s", bus.s, 32'h0);
        check_output("reset ready", 32'(bus.ready), 32'd0);
        check_output("reset busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        $display("[TB] directed conversions");

        apply_stimulus("x=1", 32'd1, 32'h3F000000, 34, 0);
        apply_stimulus("x=-6", -32'sd6, 32'hC1800000, 32, 0);
        apply_stimulus("x=0", 32'd0, 32'h00000000, 2, 0);
        apply_stimulus("x=min", 32'h80000000, 32'hDE000000, 3, 0);
        apply_stimulus("x=max", 32'h7FFFFFFF, MAX_POS_S, 4, 0);
        apply_stimulus("x=tie", 32'h02000001, 32'h58000000, 9, 0);
        apply_stimulus("start_busy", 32'd1, 32'h3F000000, 34, 6);

        // Reset in the middle of normalization discards the in-flight result.
        @(negedge clk);
        bus.start = 1'b1;
        bus.x     = 32'd1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check_output("mid busy", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        check_output("midreset s", bus.s, 32'h0);
        check_output("midreset ready", 32'(bus.ready), 32'd0);
        check_output("midreset busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus("after_reset", -32'sd6, 32'hC1800000, 32, 0);

        $display("[TB] random conversions");
        for (int i = 0; i < 16; i++) begin
            xv = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) xv = -xv;
            apply_stimulus("random", xv, ref_fp(xv), ref_latency(xv), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
